// File: rtl/sobel_threshold_ctrl.sv
// Frame-synchronous Sobel threshold controller: counts edge pixels per frame and
// publishes an adaptive or host-set threshold during vertical blanking.
module sobel_threshold_ctrl #(
  parameter logic [7:0]  THR_INIT = 8'd64,
  parameter logic [7:0]  THR_MIN  = 8'd8,
  parameter logic [7:0]  THR_MAX  = 8'd248,
  parameter logic [7:0]  THR_STEP = 8'd4,
  parameter int unsigned CNT_W    = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             post_frame_vsync,
  input  logic             post_frame_href,
  input  logic             post_img_Bit,
  input  logic             cfg_auto,
  input  logic             cfg_thr_wr,
  input  logic [7:0]       cfg_thr_data,
  input  logic [CNT_W-1:0] cfg_cnt_lo,
  input  logic [CNT_W-1:0] cfg_cnt_hi,
  output logic [7:0]       Sobel_Threshold,
  output logic [CNT_W-1:0] edge_count,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, COUNT, EVAL, APPLY} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic             vs_d;
  logic             rise, fall, pix;
  logic [CNT_W-1:0] cnt, cnt_l;
  logic             start_pend;
  logic             pend, pend_used;
  logic [7:0]       pend_val;
  logic [7:0]       nxt, nxt_c, base;
  logic [8:0]       up9, dn9;
  logic             thr_defer;
  logic [7:0]       thr_defer_val;

  assign rise = post_frame_vsync & ~vs_d;
  assign fall = ~post_frame_vsync & vs_d;
  assign pix  = post_frame_vsync & post_frame_href & post_img_Bit;

  // vs_d resets high so a frame already in progress at reset release is not seen as a rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vs_d <= 1'b1;
    else     vs_d <= post_frame_vsync;
  end

  // Saturating edge-pixel counter, restarted by each vsync rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= pix ? CNT_W'(1) : '0;
    end else if (pix && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise || start_pend) state_nxt = COUNT;
      COUNT:   if (fall) state_nxt = EVAL;
      EVAL:    state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A rise during EVAL/APPLY (short blanking) is remembered so IDLE re-enters COUNT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_pend <= 1'b0;
    end else if (state_nxt == COUNT && state != COUNT) begin
      start_pend <= 1'b0;
    end else if (rise && (state == EVAL || state == APPLY)) begin
      start_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt_l <= '0;
    else if (state == COUNT && fall) cnt_l <= cnt;
  end

  // Next-threshold selection; base includes a threshold still waiting for blanking
  always_comb begin
    base  = thr_defer ? thr_defer_val : Sobel_Threshold;
    up9   = {1'b0, base} + {1'b0, THR_STEP};
    dn9   = {1'b0, base} - {1'b0, THR_STEP};
    nxt_c = base;
    if (pend) begin
      nxt_c = pend_val;
    end else if (cfg_auto) begin
      if (cnt_l > cfg_cnt_hi) begin
        nxt_c = (up9 > {1'b0, THR_MAX}) ? THR_MAX : up9[7:0];
      end else if (cnt_l < cfg_cnt_lo) begin
        nxt_c = (dn9[8] || dn9[7:0] < THR_MIN) ? THR_MIN : dn9[7:0];
      end
    end
  end

  // Host write capture; a write landing in EVAL or APPLY survives to the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_val  <= 8'd0;
      pend_used <= 1'b0;
      nxt       <= 8'd0;
    end else begin
      if (cfg_thr_wr) begin
        pend     <= 1'b1;
        pend_val <= cfg_thr_data;
      end else if (state == APPLY && pend_used) begin
        pend <= 1'b0;
      end
      if (state == EVAL) begin
        nxt       <= nxt_c;
        pend_used <= pend & ~cfg_thr_wr;
      end
    end
  end

  // Publish results; the threshold itself is held back until vsync is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sobel_Threshold <= THR_INIT;
      edge_count      <= '0;
      frame_done      <= 1'b0;
      thr_defer       <= 1'b0;
      thr_defer_val   <= 8'd0;
    end else if (state == APPLY) begin
      edge_count <= cnt_l;
      frame_done <= 1'b1;
      if (post_frame_vsync) begin
        thr_defer     <= 1'b1;
        thr_defer_val <= nxt;
      end else begin
        Sobel_Threshold <= nxt;
        thr_defer       <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
      if (thr_defer && !post_frame_vsync) begin
        Sobel_Threshold <= thr_defer_val;
        thr_defer       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_threshold_ctrl.sv
// Directed bench for sobel_threshold_ctrl: frames are driven in sequence and the
// expected per-frame results are queued and compared when frame_done pulses.
module tb_sobel_threshold_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync, href, img_bit;
  logic        cfg_auto, cfg_thr_wr;
  logic [7:0]  cfg_thr_data;
  logic [18:0] cfg_cnt_lo, cfg_cnt_hi;
  logic [7:0]  thr;
  logic [18:0] edge_count;
  logic        frame_done;

  typedef struct {
    logic [7:0]  thr;
    logic [18:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  sobel_threshold_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .post_frame_vsync (vsync),
    .post_frame_href  (href),
    .post_img_Bit     (img_bit),
    .cfg_auto         (cfg_auto),
    .cfg_thr_wr       (cfg_thr_wr),
    .cfg_thr_data     (cfg_thr_data),
    .cfg_cnt_lo       (cfg_cnt_lo),
    .cfg_cnt_hi       (cfg_cnt_hi),
    .Sobel_Threshold  (thr),
    .edge_count       (edge_count),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic b);
    @(negedge clk);
    vsync      = v;
    href       = h;
    img_bit    = b;
    cfg_thr_wr = 1'b0;
  endtask

  // Active part of a frame: porch pixels that must not count, then n edge pixels
  task automatic frame_body(input int n, input int wr_at, input logic [7:0] wv);
    repeat (4) drive(1'b1, 1'b0, 1'b1);
    repeat (8) drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      if (i == wr_at) begin
        cfg_thr_wr   = 1'b1;
        cfg_thr_data = wv;
      end
    end
    repeat (2) drive(1'b1, 1'b0, 1'b0);
  endtask

  // Drops vsync and checks the result pulse lands exactly 3 cycles later
  task automatic end_frame(input logic [7:0] et, input int ec, input logic apply_wr,
                           input logic [7:0] av, input string tag);
    exp_t e;
    sb.push_back('{et, 19'(ec)});
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk({tag, "_fd_e0"}, 32'(frame_done), 32'd0);
    @(negedge clk);
    chk({tag, "_fd_e1"}, 32'(frame_done), 32'd0);
    if (apply_wr) begin
      cfg_thr_wr   = 1'b1;
      cfg_thr_data = av;
    end
    @(negedge clk);
    cfg_thr_wr = 1'b0;
    chk({tag, "_fd_e2"}, 32'(frame_done), 32'd1);
    e = sb.pop_front();
    chk({tag, "_thr"}, 32'(thr), 32'(e.thr));
    chk({tag, "_cnt"}, 32'(edge_count), 32'(e.cnt));
    @(negedge clk);
    chk({tag, "_fd_pulse"}, 32'(frame_done), 32'd0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; vsync = 1'b0; href = 1'b0; img_bit = 1'b0;
    cfg_auto = 1'b1; cfg_thr_wr = 1'b0; cfg_thr_data = 8'd0;
    cfg_cnt_lo = 19'd1000; cfg_cnt_hi = 19'd2000;
    repeat (3) @(negedge clk);
    chk("rst_thr", 32'(thr), 32'd64);
    chk("rst_cnt", 32'(edge_count), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0);

    // Adaptive raise
    frame_body(3000, -1, 8'd0);
    end_frame(8'd68, 3000, 1'b0, 8'd0, "raise");

    // Host override beats the step; then set 12 as the saturation start point
    frame_body(3000, 100, 8'd200);
    end_frame(8'd200, 3000, 1'b0, 8'd0, "host200");
    frame_body(1500, 10, 8'd12);
    end_frame(8'd12, 1500, 1'b0, 8'd0, "host12");

    // Downward saturation and in-window hold
    frame_body(0, -1, 8'd0);
    end_frame(8'd8, 0, 1'b0, 8'd0, "sat1");
    frame_body(0, -1, 8'd0);
    end_frame(8'd8, 0, 1'b0, 8'd0, "sat2");
    frame_body(1500, -1, 8'd0);
    end_frame(8'd8, 1500, 1'b0, 8'd0, "hold");

    // Write in the APPLY cycle shows up one frame later
    frame_body(0, -1, 8'd0);
    end_frame(8'd8, 0, 1'b1, 8'd100, "apply_wr");
    frame_body(1500, -1, 8'd0);
    end_frame(8'd100, 1500, 1'b0, 8'd0, "late_wr");

    // Reset mid-frame, released with vsync still high
    frame_body(500, -1, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_thr", 32'(thr), 32'd64);
    chk("midrst_cnt", 32'(edge_count), 32'd0);
    chk("midrst_fd", 32'(frame_done), 32'd0);
    repeat (2) drive(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    repeat (700) drive(1'b1, 1'b1, 1'b1);
    repeat (2) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_fd", 32'(frame_done), 32'd0);
    end

    // Manual mode: next full frame counted exactly, threshold held
    cfg_auto = 1'b0;
    frame_body(5000, -1, 8'd0);
    end_frame(8'd64, 5000, 1'b0, 8'd0, "manual");

    // Short blanking: one low cycle between frames
    cfg_auto = 1'b1;
    frame_body(1500, -1, 8'd0);
    sb.push_back('{8'd64, 19'd1500});
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("short_fd_e0", 32'(frame_done), 32'd0);
    vsync = 1'b1;
    @(negedge clk);
    chk("short_fd_e1", 32'(frame_done), 32'd0);
    @(negedge clk);
    chk("short_fd_e2", 32'(frame_done), 32'd1);
    e = sb.pop_front();
    chk("short_a_thr", 32'(thr), 32'(e.thr));
    chk("short_a_cnt", 32'(edge_count), 32'(e.cnt));
    repeat (6) drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2500; i++) drive(1'b1, 1'b1, 1'b1);
    repeat (2) drive(1'b1, 1'b0, 1'b0);
    end_frame(8'd68, 2500, 1'b0, 8'd0, "short_b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
